// File: rtl/target_gen.sv
// -----------------------------------------------------------------------------
// target_gen -- reaction-game target generator.
//
// Lights one pseudo-random LED at a time and waits for the player to set the
// switches to exactly that pattern. A correct response produces a one-cycle hit
// pulse and bumps a saturating hit counter. If HOLD_TICKS tick_en pulses pass
// first, a one-cycle miss pulse is produced instead. After either outcome all
// switches must be cleared before the next target is picked.
//
// Parameters:
//   SEED        LFSR reset value (must be nonzero)
//   HOLD_TICKS  tick_en pulses a target stays lit before a miss (1..15)
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   tick_en    one-cycle enable pulse from the hertz divider
//   run        game active (level)
//   sw[15:0]   player switches
//   led[15:0]  target LEDs, one-hot or zero
//   hit        one-cycle pulse on a correct response
//   miss       one-cycle pulse on timeout (or penalty)
//   hit_count  hits in the current game, saturates at 63
//
// Optional feature macro: TARGET_PENALTY_EN
//   When defined, any switch raised outside the lit target during SHOW ends
//   the round with a miss; this outranks both a hit and a timeout.
// -----------------------------------------------------------------------------
module target_gen #(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          HOLD_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_en,
  input  logic        run,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        hit,
  output logic        miss,
  output logic [5:0]  hit_count
);

  typedef enum logic [1:0] {IDLE, PICK, SHOW, WAIT_CLEAR} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_TICKS - 1);

  state_t      state_reg, state_next;
  logic [15:0] lfsr_reg;
  logic [15:0] led_reg, led_next;
  logic        hit_reg, hit_next;
  logic        miss_reg, miss_next;
  logic [5:0]  count_reg, count_next;
  logic [3:0]  hold_reg, hold_next;
  logic [15:0] pick_onehot;

  // One-hot decode of the low LFSR nibble: the target chosen in PICK.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_onehot
      assign pick_onehot[gi] = (lfsr_reg[3:0] == 4'(gi));
    end
  endgenerate

  // Free-running Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10).
  // It keeps stepping in every state so the target depends on player timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      led_reg   <= 16'h0;
      hit_reg   <= 1'b0;
      miss_reg  <= 1'b0;
      count_reg <= 6'd0;
      hold_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      led_reg   <= led_next;
      hit_reg   <= hit_next;
      miss_reg  <= miss_next;
      count_reg <= count_next;
      hold_reg  <= hold_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    led_next   = led_reg;
    hit_next   = 1'b0;
    miss_next  = 1'b0;
    count_next = count_reg;
    hold_next  = hold_reg;

    case (state_reg)
      IDLE: begin
        led_next = 16'h0;
        if (run) begin
          state_next = PICK;
          count_next = 6'd0;   // new game starts with a fresh score
        end
      end

      PICK: begin
        led_next   = pick_onehot;
        hold_next  = 4'd0;
        state_next = SHOW;
      end

      SHOW: begin
`ifdef TARGET_PENALTY_EN
        if (|(sw & ~led_reg)) begin
          miss_next  = 1'b1;
          led_next   = 16'h0;
          state_next = WAIT_CLEAR;
        end else
`endif
        // A match is checked before the timeout so that a response arriving
        // on the terminal tick still counts as a hit.
        if (sw == led_reg) begin
          hit_next   = 1'b1;
          count_next = (count_reg == 6'd63) ? count_reg : count_reg + 6'd1;
          led_next   = 16'h0;
          state_next = WAIT_CLEAR;
        end else if (tick_en) begin
          if (hold_reg == HOLD_LAST) begin
            miss_next  = 1'b1;
            led_next   = 16'h0;
            state_next = WAIT_CLEAR;
          end else begin
            hold_next = hold_reg + 4'd1;
          end
        end
      end

      WAIT_CLEAR: begin
        led_next = 16'h0;
        if (sw == 16'h0) begin
          state_next = run ? PICK : IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        led_next   = 16'h0;
      end
    endcase

    // Dropping run aborts the round silently and keeps the score on display.
    if (state_reg != IDLE && !run) begin
      state_next = IDLE;
      led_next   = 16'h0;
      hit_next   = 1'b0;
      miss_next  = 1'b0;
      count_next = count_reg;
    end
  end

  assign led       = led_reg;
  assign hit       = hit_reg;
  assign miss      = miss_reg;
  assign hit_count = count_reg;

endmodule
